// File: rtl/mem_access_ctrl_if.sv
// Handshake bundle between the pipeline/memory side and mem_access_ctrl.
// master drives controller requests and memory acks; slave is the sequencer.
interface mem_access_ctrl_if #(
    parameter int unsigned TIMEOUT_W = 8
);
    logic                 mem_req;
    logic                 mem_write;
    logic                 acki_n;
    logic                 ackd_n;
    logic                 err_clr;
    logic                 mreq;
    logic                 write;
    logic                 pc_enable;
    logic                 stall;
    logic                 bus_err;
    logic [TIMEOUT_W-1:0] wait_cnt;

    modport master (
        output mem_req, mem_write, acki_n, ackd_n, err_clr,
        input  mreq, write, pc_enable, stall, bus_err, wait_cnt
    );

    modport slave (
        input  mem_req, mem_write, acki_n, ackd_n, err_clr,
        output mreq, write, pc_enable, stall, bus_err, wait_cnt
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Bus-handshake sequencer: collects instruction/data acks per pipeline step and emits PC enable.
// Define MEMCTRL_TIMEOUT_EN to enable the wait timeout and the ERR state.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_W = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input logic               i_clk,
    input logic               i_reset_x,
    mem_access_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StErr  = 2'd2
    } state_e;

    state_e               state_q;
    logic                 i_got_q;
    logic                 d_got_q;
    logic                 bus_err_q;
    logic [TIMEOUT_W-1:0] wait_q;

    logic i_done;
    logic d_done;
    logic step_done;
    logic in_run;
    logic timeout;
    logic err_clr;

`ifdef MEMCTRL_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WaitLast = TIMEOUT_W'(TIMEOUT - 1);

    assign timeout = (wait_q == WaitLast);
    assign err_clr = bus.err_clr;
`else
    localparam int unsigned UnusedTimeout = TIMEOUT;
    logic unused_err_clr;

    assign unused_err_clr = bus.err_clr;
    assign timeout        = 1'b0;
    assign err_clr        = 1'b0;
`endif

    assign i_done    = i_got_q | ~bus.acki_n;
    assign d_done    = ~bus.mem_req | d_got_q | ~bus.ackd_n;
    assign step_done = i_done & d_done;
    assign in_run    = (state_q == StRun);

    assign bus.pc_enable = in_run & step_done;
    assign bus.stall     = ~(in_run & step_done);
    // Request drops as soon as the data ack is captured, even if ACKI is still pending.
    assign bus.mreq      = in_run & bus.mem_req & ~d_got_q;
    assign bus.write     = in_run & bus.mem_req & ~d_got_q & bus.mem_write;
    assign bus.bus_err   = bus_err_q;
    assign bus.wait_cnt  = wait_q;

    always_ff @(posedge i_clk or negedge i_reset_x) begin
        if (!i_reset_x) begin
            state_q   <= StBoot;
            i_got_q   <= 1'b0;
            d_got_q   <= 1'b0;
            bus_err_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    state_q <= StRun;
                end
                StRun: begin
                    if (step_done) begin
                        i_got_q <= 1'b0;
                        d_got_q <= 1'b0;
                        wait_q  <= '0;
                    end else if (timeout) begin
                        state_q   <= StErr;
                        bus_err_q <= 1'b1;
                        i_got_q   <= 1'b0;
                        d_got_q   <= 1'b0;
                        wait_q    <= wait_q + TIMEOUT_W'(1);
                    end else begin
                        if (!bus.acki_n) begin
                            i_got_q <= 1'b1;
                        end
                        // A data ack with no request pending is spurious.
                        if (bus.mem_req && !bus.ackd_n) begin
                            d_got_q <= 1'b1;
                        end
                        if (wait_q != '1) begin
                            wait_q <= wait_q + TIMEOUT_W'(1);
                        end
                    end
                end
                StErr: begin
                    if (err_clr) begin
                        state_q   <= StRun;
                        bus_err_q <= 1'b0;
                        wait_q    <= '0;
                    end
                end
                default: begin
                    state_q <= StBoot;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed-vector bench for mem_access_ctrl: a cycle-by-cycle table plus hand sequences
// for counter saturation (default build) or timeout/recovery (MEMCTRL_TIMEOUT_EN).
module tb_mem_access_ctrl;

    localparam int unsigned TW = 8;

    typedef struct {
        string      name;
        logic [5:0] in;   // {rst_n, mem_req, mem_write, acki_n, ackd_n, err_clr}
        logic [4:0] out;  // {pc_enable, mreq, write, stall, bus_err}
        logic [7:0] wcnt;
    } vec_t;

    logic i_clk;
    logic i_reset_x;
    int   n_vec;
    int   n_mis;
    vec_t vecs[25];

    mem_access_ctrl_if #(.TIMEOUT_W(TW)) bus ();

    mem_access_ctrl #(
        .TIMEOUT_W(TW),
        .TIMEOUT  (4)
    ) dut (
        .i_clk    (i_clk),
        .i_reset_x(i_reset_x),
        .bus      (bus)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic vec_t mk(string n, logic [5:0] in, logic [4:0] out, logic [7:0] w);
        vec_t v;
        v.name = n;
        v.in   = in;
        v.out  = out;
        v.wcnt = w;
        return v;
    endfunction

    task automatic drive(input logic [5:0] in);
        i_reset_x     = in[5];
        bus.mem_req   = in[4];
        bus.mem_write = in[3];
        bus.acki_n    = in[2];
        bus.ackd_n    = in[1];
        bus.err_clr   = in[0];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1ns later, well away from the rising edge.
    task automatic cycle(input logic [5:0] in);
        @(negedge i_clk);
        drive(in);
        #1;
    endtask

    function automatic logic [12:0] outs();
        return {bus.pc_enable, bus.mreq, bus.write, bus.stall, bus.bus_err, bus.wait_cnt};
    endfunction

    initial begin
        n_vec = 0;
        n_mis = 0;
        drive(6'b000110);

        vecs[0]  = mk("reset",      6'b000110, 5'b00010, 8'd0);
        vecs[1]  = mk("reset_ack",  6'b000010, 5'b00010, 8'd0);
        vecs[2]  = mk("boot",       6'b100010, 5'b00010, 8'd0);
        vecs[3]  = mk("zw_1",       6'b100010, 5'b10000, 8'd0);
        vecs[4]  = mk("zw_2",       6'b100010, 5'b10000, 8'd0);
        vecs[5]  = mk("zw_3",       6'b100010, 5'b10000, 8'd0);
        vecs[6]  = mk("split_c0",   6'b110100, 5'b01010, 8'd0);
        vecs[7]  = mk("split_c1",   6'b110110, 5'b00010, 8'd1);
        vecs[8]  = mk("split_c2",   6'b110110, 5'b00010, 8'd2);
        vecs[9]  = mk("split_c3",   6'b110010, 5'b10000, 8'd3);
        vecs[10] = mk("store_c0",   6'b111010, 5'b01110, 8'd0);
        vecs[11] = mk("store_c1",   6'b111010, 5'b01110, 8'd1);
        vecs[12] = mk("store_c2",   6'b111000, 5'b11100, 8'd2);
        vecs[13] = mk("spur_c0",    6'b100100, 5'b00010, 8'd0);
        vecs[14] = mk("spur_c1",    6'b100100, 5'b00010, 8'd1);
        vecs[15] = mk("spur_c2",    6'b100000, 5'b10000, 8'd2);
        vecs[16] = mk("rep_c0",     6'b110010, 5'b01010, 8'd0);
        vecs[17] = mk("rep_c1",     6'b110010, 5'b01010, 8'd1);
        vecs[18] = mk("rep_c2",     6'b110100, 5'b11000, 8'd2);
        vecs[19] = mk("b2b",        6'b110000, 5'b11000, 8'd0);
        vecs[20] = mk("mid_c0",     6'b111010, 5'b01110, 8'd0);
        vecs[21] = mk("mid_rst",    6'b011110, 5'b00010, 8'd0);
        vecs[22] = mk("mid_boot",   6'b100110, 5'b00010, 8'd0);
        vecs[23] = mk("mid_fresh",  6'b100110, 5'b00010, 8'd0);
        vecs[24] = mk("mid_done",   6'b100010, 5'b10000, 8'd1);

        foreach (vecs[i]) begin
            cycle(vecs[i].in);
            check(vecs[i].name, 32'(outs()), 32'({vecs[i].out, vecs[i].wcnt}));
            // Without a data request the data flag must never be set.
            if (!vecs[i].in[4]) begin
                check({vecs[i].name, "_dgot"}, 32'(dut.d_got_q), 32'd0);
            end
        end

`ifdef MEMCTRL_TIMEOUT_EN
        // Timeout = 4: both acks withheld on a store step.
        for (int k = 0; k < 4; k++) begin
            cycle(6'b111110);
            check($sformatf("to_wait%0d", k), 32'(outs()),
                  32'({5'b01110, 8'(k)}));
        end
        // ERR entered: strobes dropped, acks ignored.
        cycle(6'b111000);
        check("to_err_pce", 32'(bus.pc_enable), 32'd0);
        check("to_err_flags", 32'({bus.mreq, bus.write, bus.stall, bus.bus_err}), 32'b0011);
        cycle(6'b111111);
        check("to_err_hold", 32'(bus.bus_err), 32'd1);
        cycle(6'b111000);
        check("to_recover", 32'(outs()), 32'({5'b11100, 8'd0}));
`else
        // Withheld acks with err_clr pulsing: no error, counter sticks at all-ones.
        for (int k = 0; k < 260; k++) begin
            cycle(6'b100111);
            if (k == 10) begin
                check("sat_wait10", 32'(bus.wait_cnt), 32'd10);
            end
        end
        check("sat_cnt", 32'(outs()), 32'({5'b00010, 8'd255}));
        cycle(6'b100010);
        check("sat_done", 32'(outs()), 32'({5'b10000, 8'd255}));
        cycle(6'b100010);
        check("sat_next", 32'(outs()), 32'({5'b10000, 8'd0}));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
